// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage controller.
//   state_t          : 2-bit FSM encoding (IDLE/BUSY/DONE/HALTED)
//   TIMEOUT_DEFAULT  : default number of BUSY cycles before a request is abandoned
//   is_misaligned()  : 16-bit accesses must sit on even addresses
package mem_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTR_W  = 8;

  localparam logic [CTR_W-1:0] TIMEOUT_DEFAULT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY   = 2'b01,
    ST_DONE   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/dff.sv
// Generic register cell with asynchronous active-low reset to zero.
//   clk   : clock
//   rst_n : asynchronous reset, active low
//   d / q : W-bit data in / registered out
module dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/mem_timeout_ctr.sv
// BUSY wait counter for the MEM-stage controller.
//   clr   : force count to zero (held while not waiting)
//   en    : count one waiting cycle
//   tc_o  : the current cycle is the TIMEOUT-th waiting cycle
// count_q holds the number of waiting cycles already completed, so the
// terminal compare is against TIMEOUT-1: tc_o rises during the cycle in
// which the wait reaches TIMEOUT cycles.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter logic [CTR_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_o
);

  localparam logic [CTR_W-1:0] TC_VAL = TIMEOUT - CTR_W'(1);

  logic [CTR_W-1:0] count_d;
  logic [CTR_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CTR_W'(1);
  end

  dff #(.W(CTR_W)) u_count_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (count_d),
    .q     (count_q)
  );

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline-stage controller: passes ALU results through with zero
// latency, sequences aligned loads/stores against a memory that answers
// with a single-cycle mem_done pulse, flags misaligned accesses and
// timeouts, and parks in HALTED after a halt instruction.
//   clk, rst                         : clock, async active-low reset
//   in_valid, mem_read, mem_write,
//   halt, address, write_data        : EX/MEM stage inputs
//   mem_rdata, mem_done              : memory response
//   mem_addr, mem_wdata, mem_rd,
//   mem_wr                           : memory request (BUSY only)
//   stall_o                          : freeze upstream stages
//   out_valid, data_read, address_o,
//   excp_o                           : result toward MEM/WB register
//   halted_o                         : core halted until reset
//
// state  | meaning
// IDLE   | accept next instruction; ALU/misaligned/halt answer same cycle
// BUSY   | memory request outstanding, waiting for mem_done or timeout
// DONE   | one-cycle result presentation of the finished memory op
// HALTED | halt retired; stall forever until reset
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter logic [CTR_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              halt,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              stall_o,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] address_o,
  output logic              excp_o,
  output logic              halted_o
);

  state_t            state_d, state_q;
  logic [1:0]        state_bits_q;
  logic [DATA_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              op_rd_d, op_rd_q;
  logic              op_wr_d, op_wr_q;
  logic              excp_d, excp_q;
  logic              timeout_tc;
  logic              is_mem_op;
  logic              issue;
  logic              busy_exit;

  assign is_mem_op = mem_read | mem_write;

  // ---------------- state register ----------------
  dff #(.W(2)) u_state_q (
    .clk   (clk),
    .rst_n (rst),
    .d     (state_d),
    .q     (state_bits_q)
  );
  assign state_q = state_t'(state_bits_q);

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // halt takes priority over any memory op on the same instruction
          if (halt)                                          state_d = ST_HALTED;
          else if (is_mem_op && !is_misaligned(address))     state_d = ST_BUSY;
        end
      end
      ST_BUSY:   if (mem_done || timeout_tc) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign issue     = (state_q == ST_IDLE) && (state_d == ST_BUSY);
  assign busy_exit = (state_q == ST_BUSY) && (state_d == ST_DONE);

  // ---------------- latched request / result ----------------
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    excp_d  = excp_q;
    if (issue) begin
      addr_d  = address;
      wdata_d = write_data;
      // read+write together is a store
      op_wr_d = mem_write;
      op_rd_d = mem_read & ~mem_write;
      rdata_d = '0;
      excp_d  = 1'b0;
    end
    if (busy_exit) begin
      // mem_done beats a simultaneous timeout
      if (mem_done) begin
        rdata_d = op_wr_q ? '0 : mem_rdata;
        excp_d  = 1'b0;
      end else begin
        rdata_d = '0;
        excp_d  = 1'b1;
      end
    end
  end

  dff #(.W(DATA_W)) u_addr_q  (.clk(clk), .rst_n(rst), .d(addr_d),  .q(addr_q));
  dff #(.W(DATA_W)) u_wdata_q (.clk(clk), .rst_n(rst), .d(wdata_d), .q(wdata_q));
  dff #(.W(DATA_W)) u_rdata_q (.clk(clk), .rst_n(rst), .d(rdata_d), .q(rdata_q));
  dff #(.W(1))      u_op_rd_q (.clk(clk), .rst_n(rst), .d(op_rd_d), .q(op_rd_q));
  dff #(.W(1))      u_op_wr_q (.clk(clk), .rst_n(rst), .d(op_wr_d), .q(op_wr_q));
  dff #(.W(1))      u_excp_q  (.clk(clk), .rst_n(rst), .d(excp_d),  .q(excp_q));

  // ---------------- wait counter ----------------
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst),
    .clr   (state_q != ST_BUSY),
    .en    (state_q == ST_BUSY),
    .tc_o  (timeout_tc)
  );

  // ---------------- outputs ----------------
  // IDLE responses are combinational from the stage inputs, so everything
  // is additionally gated by rst to hold all outputs low during reset.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    stall_o   = 1'b0;
    out_valid = 1'b0;
    data_read = '0;
    address_o = '0;
    excp_o    = 1'b0;
    halted_o  = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (halt) begin
              out_valid = 1'b1;
              address_o = address;
            end else if (is_mem_op) begin
              if (is_misaligned(address)) begin
                out_valid = 1'b1;
                excp_o    = 1'b1;
                address_o = address;
              end else begin
                stall_o   = 1'b1;
              end
            end else begin
              out_valid = 1'b1;
              address_o = address;
            end
          end
        end
        ST_BUSY: begin
          stall_o   = 1'b1;
          mem_rd    = op_rd_q;
          mem_wr    = op_wr_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        ST_DONE: begin
          out_valid = 1'b1;
          data_read = rdata_q;
          address_o = addr_q;
          excp_o    = excp_q;
        end
        ST_HALTED: begin
          stall_o  = 1'b1;
          halted_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, mem_read, mem_write, halt, mem_done;
  logic [15:0] address, write_data, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, data_read, address_o;
  logic        mem_rd, mem_wr, stall_o, out_valid, excp_o, halted_o;

  mem_stage_ctrl #(.TIMEOUT(8'd255)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .halt       (halt),
    .address    (address),
    .write_data (write_data),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .stall_o    (stall_o),
    .out_valid  (out_valid),
    .data_read  (data_read),
    .address_o  (address_o),
    .excp_o     (excp_o),
    .halted_o   (halted_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        excp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must report for one instruction and how
  // many BUSY cycles it must spend, derived from the stage rules directly.
  task automatic model(input bit rd, input bit wr, input bit hlt,
                       input logic [15:0] addr, input logic [15:0] rdata,
                       input int done_at, output exp_t r, output int busy_n);
    r.addr = addr; r.data = 16'h0; r.excp = 1'b0; busy_n = 0;
    if (hlt || !(rd || wr)) return;
    if (addr[0]) begin r.excp = 1'b1; return; end
    if (done_at >= 1 && done_at <= TMO) begin
      busy_n = done_at;
      r.data = wr ? 16'h0 : rdata;
    end else begin
      busy_n = TMO;
      r.excp = 1'b1;
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got address_o=%0h, expected no result", address_o);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_address", 128'(address_o), 128'(e.addr));
          check_eq("out_data",    128'(data_read), 128'(e.data));
          check_eq("out_excp",    128'(excp_o),    128'(e.excp));
        end
      end
    end
  end

  task automatic run_txn(input bit rd, input bit wr, input bit hlt,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdata, input int done_at);
    exp_t e;
    int   nb;
    bit   exp_rd, exp_wr;
    model(rd, wr, hlt, addr, rdata, done_at, e, nb);
    exp_rd = rd & ~wr;
    exp_wr = wr;
    @(posedge clk); #1;
    in_valid = 1'b1; mem_read = rd; mem_write = wr; halt = hlt;
    address = addr; write_data = wdata;
    mem_rdata = 16'($urandom); mem_done = 1'($urandom_range(0, 1));
    exp_q.push_back(e);
    @(negedge clk);
    if (nb > 0)
      check_eq("issue_cycle", 128'({stall_o, mem_rd, mem_wr}), 128'(3'b100));
    else if (!hlt)
      check_eq("same_cycle", 128'({stall_o, mem_rd, mem_wr}), 128'(3'b000));
    for (int k = 1; k <= nb; k++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      halt = 1'($urandom); address = 16'($urandom); write_data = 16'($urandom);
      mem_done  = (k == done_at);
      mem_rdata = (k == done_at) ? rdata : 16'($urandom);
      @(negedge clk);
      check_eq("busy_request",
               128'({stall_o, out_valid, mem_rd, mem_wr, mem_addr, mem_wdata}),
               128'({1'b1, 1'b0, exp_rd, exp_wr, addr, wdata}));
    end
    if (nb > 0) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); halt = 1'b0; mem_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("done_cycle", 128'({out_valid, stall_o, mem_rd, mem_wr}), 128'(4'b1000));
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_valid = 1'b0; halt = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    address = 16'($urandom); mem_done = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("idle_quiet", 128'({out_valid, stall_o, mem_rd, mem_wr}), 128'(4'b0000));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, op, dly;
    logic [15:0] a, wd, rdv;
    in_valid = 0; mem_read = 0; mem_write = 0; halt = 0; mem_done = 0;
    address = 0; write_data = 0; mem_rdata = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs",
             128'({mem_addr, mem_wdata, mem_rd, mem_wr, stall_o, out_valid,
                   data_read, address_o, excp_o, halted_o}), 128'(0));
    rst = 1'b1;

    run_txn(1, 0, 0, 16'h0040, 16'h5555, 16'hBEEF, 3);
    run_txn(0, 1, 0, 16'h0102, 16'h1234, 16'hAAAA, 1);
    run_txn(1, 0, 0, 16'h0041, 16'h0000, 16'h0000, 0);
    run_txn(1, 1, 0, 16'h0200, 16'hCAFE, 16'h7777, 2);
    run_txn(1, 0, 0, 16'h0300, 16'h0000, 16'h1111, 0);
    run_txn(1, 0, 0, 16'h0302, 16'h0000, 16'h2222, TMO);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      a    = 16'($urandom);
      wd   = 16'($urandom);
      rdv  = 16'($urandom);
      dly  = $urandom_range(1, 6);
      op   = $urandom_range(1, 3);
      if (kind <= 1)      run_txn(0, 0, 0, a, wd, rdv, 0);
      else if (kind == 2) run_txn(op[0], op[1], 0, a | 16'h0001, wd, rdv, dly);
      else                run_txn(op[0], op[1], 0, a & 16'hFFFE, wd, rdv, dly);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset in the middle of a read
    @(posedge clk); #1;
    in_valid = 1; mem_read = 1; mem_write = 0; halt = 0; address = 16'h0080; mem_done = 0;
    @(posedge clk); #1;
    in_valid = 0; mem_read = 0;
    @(negedge clk);
    check_eq("pre_reset_busy", 128'({mem_rd, stall_o, mem_addr}), 128'({2'b11, 16'h0080}));
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("async_reset_drop",
             128'({mem_addr, mem_wdata, mem_rd, mem_wr, stall_o, out_valid,
                   data_read, address_o, excp_o, halted_o}), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    run_txn(0, 0, 0, 16'h0007, 16'h0000, 16'h0000, 0);
    run_txn(1, 0, 0, 16'h0010, 16'h0000, 16'h4321, 2);

    // Halt
    run_txn(0, 0, 1, 16'h0F00, 16'h0000, 16'h0000, 0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      halt = 1'($urandom); address = 16'($urandom); mem_done = 1'($urandom);
      @(negedge clk);
      check_eq("halted_hold", 128'({stall_o, halted_o, out_valid, mem_rd, mem_wr}),
               128'(5'b11000));
    end

    repeat (2) @(negedge clk);
    check_eq("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
